bin2bcd_converter: RTL
======================

BIN2BCD_CONVERTER -- requirements
Module: bin2bcd_converter

Interface
REQ-001 SHALL have parameter DIGITS, default 6, number of display digits produced.
REQ-002 SHALL have parameter WIDTH, default 32, binary input width (two's complement).
REQ-003 SHALL have ports: fnd_clk input 1, sole clock; rising edge only.
REQ-004 SHALL have ports: rst input 1, reset; asynchronous, active-high.
REQ-005 SHALL have ports: fnd_serial input WIDTH, signed value to convert, from interface stage.
REQ-006 SHALL have ports: start input 1, request conversion of fnd_serial.
REQ-007 SHALL have ports: busy output 1, conversion in progress.
REQ-008 SHALL have ports: done output 1, one-cycle result-valid pulse.
REQ-009 SHALL have ports: bcd output 4*DIGITS, packed BCD, digit 0 in [3:0].
REQ-010 SHALL have ports: neg output 1, result is negative.
REQ-011 SHALL have ports: ovf output 1, magnitude does not fit the display.

Function
REQ-012 SHALL implement FSM with states IDLE, SHIFT, FINISH.
REQ-013 IDLE: start=1 at an edge SHALL capture |fnd_serial| into a WIDTH-bit unsigned shift register, capture sign into an internal register, clear a (WIDTH+8)-bit BCD scratch (10 digits), clear the iteration counter, and go to SHIFT.
REQ-014 |fnd_serial| SHALL be computed as unsigned WIDTH-bit; -2^31 SHALL yield 2^31 (no wrap to negative).
REQ-015 SHALL perform one double-dabble step per cycle in SHIFT: each scratch digit >=5 gets +3, then {scratch, shift} shifts left 1.
REQ-016 SHALL stay in SHIFT exactly WIDTH cycles, then go to FINISH.
REQ-017 FINISH SHALL load outputs in one cycle, pulse done=1 for exactly one cycle, and return to IDLE.
REQ-018 Latency: done SHALL be high in the cycle beginning WIDTH+1 edges after the edge that sampled start (33 for WIDTH=32).
REQ-019 busy SHALL be 1 from the edge sampling start through the edge that raises done; 0 while done=1 and in IDLE.
REQ-020 ovf SHALL be 1 when any scratch digit >= DIGITS is nonzero, or when negative and digit DIGITS-1 is nonzero (minus sign occupies leftmost digit).
REQ-021 On ovf=1, bcd SHALL be all zeros; neg SHALL still reflect input sign.
REQ-022 neg SHALL be 0 for input 0 (no "-0").
REQ-023 bcd/neg/ovf SHALL hold their values until the next FINISH.
REQ-024 start while busy SHALL be ignored (no restart, no queueing).
REQ-025 start asserted in the same cycle done=1 SHALL be accepted (FSM is in IDLE then).
REQ-026 fnd_serial changes after the capture edge SHALL NOT affect the running conversion.

Reset
REQ-027 rst=1 SHALL asynchronously force IDLE, busy=0, done=0, bcd=0, neg=0, ovf=0, counter=0, scratch=0.
REQ-028 Reset during SHIFT or FINISH SHALL abort the conversion with no done pulse.
REQ-029 After rst deasserts, first start SHALL be accepted on the first rising edge.

Structure
REQ-030 calc_pkg SHALL hold FSM state encoding, DIGITS/WIDTH defaults and the 4-bit BCD digit type.
REQ-031 SHALL instantiate one sub-module, bcd_add3: combinational 4-bit digit in, digit+3 if >=5 out; one instance per scratch digit.
REQ-032 No arithmetic divide or modulo operators SHALL be used.

Verification
REQ-033 fnd_serial=123456, start pulse -> 33 cycles later done=1, bcd=0x123456, neg=0, ovf=0; busy high all 33 cycles.
REQ-034 fnd_serial=-12345 -> bcd=0x012345, neg=1, ovf=0; fnd_serial=-99999 -> bcd=0x099999, neg=1, ovf=0.
REQ-035 fnd_serial=999999 -> bcd=0x999999, ovf=0; 1000000 -> ovf=1, bcd=0; -100000 -> ovf=1, neg=1; -2147483648 -> ovf=1, neg=1.
REQ-036 fnd_serial=0 -> bcd=0x000000, neg=0, ovf=0; then start re-asserted on the done cycle with 7 -> second done 33 cycles later, bcd=0x000007.
REQ-037 Start with 123; at cycle 10 start again with 456 -> single done, bcd=0x000123; rst pulse at cycle 20 of a later conversion -> no done, all outputs 0, next start converts normally.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types for the binary-to-BCD display path: FSM encoding, default sizing, BCD digit type.
package calc_pkg;

    localparam int DIGITS_DEF = 6;
    localparam int WIDTH_DEF  = 32;

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more; purely combinational.
module bcd_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bin2bcd_converter.sv
// Signed binary to packed BCD via serial double-dabble; done pulses WIDTH+1 edges after start.
// No queueing: start is ignored while busy, accepted again in the done cycle.
module bin2bcd_converter
    import calc_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF,
    parameter int WIDTH  = WIDTH_DEF
) (
    input  logic                  fnd_clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      fnd_serial,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  ovf
);

    // Scratch is sized to hold every decimal digit of a WIDTH-bit magnitude (10 digits for 32 bits).
    localparam int SCR_DIG = (WIDTH + 11) >> 2;
    localparam int SCR_W   = 4 * SCR_DIG;
    localparam int CW      = $clog2(WIDTH);

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      shift_q, shift_d;
    logic [SCR_W-1:0]      scratch_q, scratch_d, scratch_adj;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  sign_q, sign_d;
    logic                  done_q, done_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  neg_q, neg_d;
    logic                  ovf_q, ovf_d;
    logic [WIDTH-1:0]      mag;
    logic                  ovf_calc;

    // Unsigned negate keeps -2^(WIDTH-1) as the positive magnitude 2^(WIDTH-1).
    assign mag = fnd_serial[WIDTH-1] ? ((~fnd_serial) + WIDTH'(1)) : fnd_serial;

    for (genvar g = 0; g < SCR_DIG; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (scratch_q[4*g +: 4]),
            .digit_o (scratch_adj[4*g +: 4])
        );
    end

    // A negative result gives up its leftmost display digit to the minus sign.
    assign ovf_calc = (|scratch_q[SCR_W-1:4*DIGITS])
                   || (sign_q && (|scratch_q[4*DIGITS-1 -: 4]));

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = mag;
                    sign_d    = fnd_serial[WIDTH-1];
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                neg_d   = sign_q;
                ovf_d   = ovf_calc;
                bcd_d   = ovf_calc ? '0 : scratch_q[4*DIGITS-1:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge fnd_clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign bcd  = bcd_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;

endmodule
